mem_port_arbiter: RTL and testbench

//  Shares the single tagged memory port between three requesters: Dcache, Icache

---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and memory-side signals around mem_port_arbiter.
// The arbiter uses the slave modport; the caches/prefetcher/memory side uses master.
interface mem_port_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned CMD_W  = 2;

  logic              dc_req;
  logic              ic_req;
  logic              pf_req;
  logic [CMD_W-1:0]  dc_cmd;
  logic [ADDR_W-1:0] dc_addr;
  logic [ADDR_W-1:0] ic_addr;
  logic [ADDR_W-1:0] pf_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              pf_flush;

  logic [TAG_W-1:0]  mem2proc_response;
  logic [TAG_W-1:0]  mem2proc_tag;
  logic [DATA_W-1:0] mem2proc_data;

  logic [CMD_W-1:0]  proc2mem_command;
  logic [ADDR_W-1:0] proc2mem_addr;
  logic [DATA_W-1:0] proc2mem_data;

  logic              dc_gnt;
  logic              ic_gnt;
  logic              pf_gnt;
  logic [TAG_W-1:0]  dc_rtag;
  logic [TAG_W-1:0]  ic_rtag;
  logic [TAG_W-1:0]  pf_rtag;
  logic              dc_rvalid;
  logic              ic_rvalid;
  logic              pf_rvalid;
  logic [DATA_W-1:0] ret_data;
  logic [TAG_W-1:0]  ret_tag;
  logic [TAG_W-1:0]  outstanding;

  modport slave (
    input  dc_req, ic_req, pf_req, dc_cmd, dc_addr, ic_addr, pf_addr, dc_wdata, pf_flush,
    input  mem2proc_response, mem2proc_tag, mem2proc_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output dc_gnt, ic_gnt, pf_gnt, dc_rtag, ic_rtag, pf_rtag,
    output dc_rvalid, ic_rvalid, pf_rvalid, ret_data, ret_tag, outstanding
  );

  modport master (
    output dc_req, ic_req, pf_req, dc_cmd, dc_addr, ic_addr, pf_addr, dc_wdata, pf_flush,
    output mem2proc_response, mem2proc_tag, mem2proc_data,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  dc_gnt, ic_gnt, pf_gnt, dc_rtag, ic_rtag, pf_rtag,
    input  dc_rvalid, ic_rvalid, pf_rvalid, ret_data, ret_tag, outstanding
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one tagged memory port between Dcache, Icache and prefetcher; tracks load-tag owners
// and routes returns. Optional feature macro: MEM_ARB_PF_DROP_EN (drop squashed prefetch returns).
module mem_port_arbiter #(
  parameter int unsigned NUM_TAGS     = 16,
  parameter int unsigned MAX_OUTSTAND = 12,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic             clock,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned TAG_W  = $clog2(NUM_TAGS);
  localparam int unsigned CNT_W  = TAG_W;
  localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {SEL_NONE, SEL_DC, SEL_IC, SEL_PF} sel_e;

  logic [NUM_TAGS-1:0] tbl_valid;
  sel_e                tbl_owner [NUM_TAGS];
`ifdef MEM_ARB_PF_DROP_EN
  logic [NUM_TAGS-1:0] tbl_drop;
`endif
  logic [CNT_W-1:0]    out_cnt;
  logic [STV_W-1:0]    starve_cnt;

  sel_e       sel;
  sel_e       ret_owner;
  logic       stall;
  logic       dc_load;
  logic       dc_store;
  logic       pf_forced;
  logic       accept;
  logic       load_acc;
  logic       ret_hit;
  logic       ret_deliver;
  logic [TAG_W-1:0] resp_tag;
  logic [TAG_W-1:0] ret_idx;

  assign resp_tag  = bus.mem2proc_response;
  assign ret_idx   = bus.mem2proc_tag;
  assign stall     = (out_cnt == CNT_W'(MAX_OUTSTAND));
  assign dc_load   = (bus.dc_cmd == BUS_LOAD);
  assign dc_store  = (bus.dc_cmd == BUS_STORE);
  assign pf_forced = (starve_cnt == STV_W'(STARVE_LIMIT));

  // Requester selection: Dcache first, then a starved prefetch, then Icache, then prefetch.
  always_comb begin
    sel = SEL_NONE;
    if (reset) begin
      sel = SEL_NONE;
    end else if (bus.dc_req && (dc_store || (dc_load && !stall))) begin
      sel = SEL_DC;
    end else if (!stall && bus.pf_req && pf_forced) begin
      sel = SEL_PF;
    end else if (!stall && bus.ic_req) begin
      sel = SEL_IC;
    end else if (!stall && bus.pf_req) begin
      sel = SEL_PF;
    end
  end

  assign accept    = (sel != SEL_NONE) && (resp_tag != '0);
  assign load_acc  = accept && !((sel == SEL_DC) && dc_store);
  assign ret_hit   = !reset && (ret_idx != '0) && tbl_valid[ret_idx];
  assign ret_owner = tbl_owner[ret_idx];

`ifdef MEM_ARB_PF_DROP_EN
  assign ret_deliver = ret_hit && !tbl_drop[ret_idx];
`else
  logic unused_pf_flush;
  assign unused_pf_flush = bus.pf_flush;
  assign ret_deliver     = ret_hit;
`endif

  // Memory command, grants, accepted tags and return routing.
  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.dc_gnt           = 1'b0;
    bus.ic_gnt           = 1'b0;
    bus.pf_gnt           = 1'b0;
    bus.dc_rtag          = '0;
    bus.ic_rtag          = '0;
    bus.pf_rtag          = '0;
    bus.dc_rvalid        = 1'b0;
    bus.ic_rvalid        = 1'b0;
    bus.pf_rvalid        = 1'b0;
    case (sel)
      SEL_DC: begin
        bus.proc2mem_command = bus.dc_cmd;
        bus.proc2mem_addr    = bus.dc_addr;
        bus.proc2mem_data    = bus.dc_wdata;
      end
      SEL_IC: begin
        bus.proc2mem_command = BUS_LOAD;
        bus.proc2mem_addr    = bus.ic_addr;
      end
      SEL_PF: begin
        bus.proc2mem_command = BUS_LOAD;
        bus.proc2mem_addr    = bus.pf_addr;
      end
      default: begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = ADDR_W'(0);
        bus.proc2mem_data    = DATA_W'(0);
      end
    endcase
    if (accept) begin
      case (sel)
        SEL_DC:  begin bus.dc_gnt = 1'b1; bus.dc_rtag = resp_tag; end
        SEL_IC:  begin bus.ic_gnt = 1'b1; bus.ic_rtag = resp_tag; end
        SEL_PF:  begin bus.pf_gnt = 1'b1; bus.pf_rtag = resp_tag; end
        default: ;
      endcase
    end
    if (ret_deliver) begin
      case (ret_owner)
        SEL_DC:  bus.dc_rvalid = 1'b1;
        SEL_IC:  bus.ic_rvalid = 1'b1;
        SEL_PF:  bus.pf_rvalid = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ret_data    = bus.mem2proc_data;
  assign bus.ret_tag     = bus.mem2proc_tag;
  assign bus.outstanding = out_cnt;

  // In-flight load count: accept and return in the same cycle cancel out.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_cnt <= '0;
    end else begin
      out_cnt <= out_cnt + CNT_W'(load_acc) - CNT_W'(ret_hit);
    end
  end

  // Prefetch starvation counter, saturating at the force threshold.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.pf_req || (accept && (sel == SEL_PF))) begin
      starve_cnt <= '0;
    end else if ((sel != SEL_PF) && !pf_forced) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Tag table: flush marks, then return clear, then new allocation (later writes win).
  always_ff @(posedge clock) begin
    if (reset) begin
      tbl_valid <= '0;
`ifdef MEM_ARB_PF_DROP_EN
      tbl_drop  <= '0;
`endif
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        tbl_owner[i] <= SEL_NONE;
      end
    end else begin
`ifdef MEM_ARB_PF_DROP_EN
      for (int unsigned i = 1; i < NUM_TAGS; i++) begin
        if (bus.pf_flush && tbl_valid[i] && (tbl_owner[i] == SEL_PF)) begin
          tbl_drop[i] <= 1'b1;
        end
      end
`endif
      if (ret_hit) begin
        tbl_valid[ret_idx] <= 1'b0;
`ifdef MEM_ARB_PF_DROP_EN
        tbl_drop[ret_idx]  <= 1'b0;
`endif
      end
      if (load_acc) begin
        tbl_valid[resp_tag] <= 1'b1;
        tbl_owner[resp_tag] <= sel;
`ifdef MEM_ARB_PF_DROP_EN
        tbl_drop[resp_tag]  <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: arbitration, starvation, stall,
// reject/retry, tag routing, same-cycle accept/return, reset and prefetch drop.
module tb_mem_port_arbiter;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mem_port_arbiter_if bus_if ();

  mem_port_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef MEM_ARB_PF_DROP_EN
  localparam logic EXP_PF_RV = 1'b0;
`else
  localparam logic EXP_PF_RV = 1'b1;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus_if.dc_req            = 1'b0;
    bus_if.ic_req            = 1'b0;
    bus_if.pf_req            = 1'b0;
    bus_if.dc_cmd            = 2'd1;
    bus_if.dc_addr           = 32'h0;
    bus_if.ic_addr           = 32'h0;
    bus_if.pf_addr           = 32'h0;
    bus_if.dc_wdata          = 64'h0;
    bus_if.pf_flush          = 1'b0;
    bus_if.mem2proc_response = 4'd0;
    bus_if.mem2proc_tag      = 4'd0;
    bus_if.mem2proc_data     = 64'h0;
  endtask

  // Present a return with no requests, check routing, advance one cycle.
  task automatic ret(input logic [3:0] tag, input logic dc, input logic ic, input logic pf);
    idle();
    bus_if.mem2proc_tag  = tag;
    bus_if.mem2proc_data = {60'h0, tag};
    #1;
    chk("ret_dc_rvalid", 64'(bus_if.dc_rvalid), 64'(dc));
    chk("ret_ic_rvalid", 64'(bus_if.ic_rvalid), 64'(ic));
    chk("ret_pf_rvalid", 64'(bus_if.pf_rvalid), 64'(pf));
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1'b1;
    tick();
    // Outputs forced idle while reset is high, even with a request and a response.
    bus_if.dc_req            = 1'b1;
    bus_if.dc_addr           = 32'h80;
    bus_if.mem2proc_response = 4'd1;
    #1;
    chk("rst_cmd", 64'(bus_if.proc2mem_command), 64'd0);
    chk("rst_addr", 64'(bus_if.proc2mem_addr), 64'd0);
    chk("rst_dc_gnt", 64'(bus_if.dc_gnt), 64'd0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_outstanding", 64'(bus_if.outstanding), 64'd0);

    // 1: Icache load then its return
    bus_if.ic_req = 1'b1; bus_if.ic_addr = 32'h100; bus_if.mem2proc_response = 4'd3;
    #1;
    chk("t1_ic_gnt", 64'(bus_if.ic_gnt), 64'd1);
    chk("t1_ic_rtag", 64'(bus_if.ic_rtag), 64'd3);
    chk("t1_cmd", 64'(bus_if.proc2mem_command), 64'd1);
    chk("t1_addr", 64'(bus_if.proc2mem_addr), 64'h100);
    tick();
    chk("t1_out1", 64'(bus_if.outstanding), 64'd1);
    idle();
    bus_if.mem2proc_tag = 4'd3; bus_if.mem2proc_data = 64'hdead_beef_0123_4567;
    #1;
    chk("t1_ic_rvalid", 64'(bus_if.ic_rvalid), 64'd1);
    chk("t1_ret_data", bus_if.ret_data, 64'hdead_beef_0123_4567);
    chk("t1_ret_tag", 64'(bus_if.ret_tag), 64'd3);
    tick();
    chk("t1_out0", 64'(bus_if.outstanding), 64'd0);
    ret(4'd3, 1'b0, 1'b0, 1'b0);
    chk("t1_stale_out", 64'(bus_if.outstanding), 64'd0);

    // 2: fixed priority dc > ic > pf
    idle();
    bus_if.dc_req = 1'b1; bus_if.ic_req = 1'b1; bus_if.pf_req = 1'b1;
    bus_if.dc_addr = 32'h200; bus_if.ic_addr = 32'h300; bus_if.pf_addr = 32'h400;
    bus_if.mem2proc_response = 4'd5;
    #1;
    chk("t2_dc_gnt", 64'(bus_if.dc_gnt), 64'd1);
    chk("t2_ic_gnt0", 64'(bus_if.ic_gnt), 64'd0);
    chk("t2_pf_gnt0", 64'(bus_if.pf_gnt), 64'd0);
    chk("t2_dc_rtag", 64'(bus_if.dc_rtag), 64'd5);
    tick();
    bus_if.dc_req = 1'b0; bus_if.mem2proc_response = 4'd6;
    #1;
    chk("t2_ic_gnt", 64'(bus_if.ic_gnt), 64'd1);
    chk("t2_pf_gnt_b", 64'(bus_if.pf_gnt), 64'd0);
    tick();
    bus_if.ic_req = 1'b0; bus_if.mem2proc_response = 4'd7;
    #1;
    chk("t2_pf_gnt", 64'(bus_if.pf_gnt), 64'd1);
    chk("t2_pf_rtag", 64'(bus_if.pf_rtag), 64'd7);
    chk("t2_pf_addr", 64'(bus_if.proc2mem_addr), 64'h400);
    tick();
    chk("t2_out3", 64'(bus_if.outstanding), 64'd3);
    ret(4'd5, 1'b1, 1'b0, 1'b0);
    ret(4'd6, 1'b0, 1'b1, 1'b0);
    ret(4'd7, 1'b0, 1'b0, 1'b1);
    chk("t2_out0", 64'(bus_if.outstanding), 64'd0);

    // 3: prefetch starvation forces a grant after 8 losses to Icache
    idle();
    bus_if.ic_req = 1'b1; bus_if.pf_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus_if.mem2proc_response = 4'(i);
      #1;
      chk("t3_ic_wins", 64'(bus_if.ic_gnt), 64'd1);
      tick();
    end
    bus_if.mem2proc_response = 4'd9;
    #1;
    chk("t3_pf_forced", 64'(bus_if.pf_gnt), 64'd1);
    chk("t3_ic_loses", 64'(bus_if.ic_gnt), 64'd0);
    tick();
    bus_if.mem2proc_response = 4'd10;
    #1;
    chk("t3_cnt_cleared", 64'(bus_if.ic_gnt), 64'd1);
    tick();
    chk("t3_out10", 64'(bus_if.outstanding), 64'd10);
    for (int i = 1; i <= 10; i++) ret(4'(i), 1'b0, (i != 9), (i == 9));
    chk("t3_out0", 64'(bus_if.outstanding), 64'd0);

    // 4: stall at 12 in flight; stores still issue
    idle();
    bus_if.ic_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      bus_if.mem2proc_response = 4'(i);
      tick();
    end
    chk("t4_out12", 64'(bus_if.outstanding), 64'd12);
    bus_if.mem2proc_response = 4'd13;
    #1;
    chk("t4_ic_stalled", 64'(bus_if.ic_gnt), 64'd0);
    chk("t4_cmd_none", 64'(bus_if.proc2mem_command), 64'd0);
    bus_if.dc_req = 1'b1; bus_if.dc_cmd = 2'd2; bus_if.dc_addr = 32'h500;
    bus_if.dc_wdata = 64'h1122_3344_5566_7788;
    #1;
    chk("t4_st_gnt", 64'(bus_if.dc_gnt), 64'd1);
    chk("t4_st_cmd", 64'(bus_if.proc2mem_command), 64'd2);
    chk("t4_st_data", bus_if.proc2mem_data, 64'h1122_3344_5566_7788);
    tick();
    chk("t4_st_no_alloc", 64'(bus_if.outstanding), 64'd12);
    bus_if.dc_cmd = 2'd1;
    #1;
    chk("t4_dc_ld_stalled", 64'(bus_if.dc_gnt), 64'd0);
    bus_if.dc_req = 1'b0; bus_if.mem2proc_tag = 4'd1;
    #1;
    chk("t4_ret_ic", 64'(bus_if.ic_rvalid), 64'd1);
    chk("t4_still_stalled", 64'(bus_if.ic_gnt), 64'd0);
    tick();
    bus_if.mem2proc_tag = 4'd0;
    #1;
    chk("t4_ic_resume", 64'(bus_if.ic_gnt), 64'd1);
    chk("t4_ic_rtag", 64'(bus_if.ic_rtag), 64'd13);
    tick();
    for (int i = 2; i <= 13; i++) ret(4'(i), 1'b0, 1'b1, 1'b0);
    chk("t4_out0", 64'(bus_if.outstanding), 64'd0);

    // 5: rejected requests leave no trace; retry succeeds
    idle();
    bus_if.dc_req = 1'b1; bus_if.dc_addr = 32'h600;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_rej_gnt", 64'(bus_if.dc_gnt), 64'd0);
      tick();
    end
    chk("t5_rej_out", 64'(bus_if.outstanding), 64'd0);
    bus_if.mem2proc_response = 4'd9;
    #1;
    chk("t5_dc_gnt", 64'(bus_if.dc_gnt), 64'd1);
    chk("t5_dc_rtag", 64'(bus_if.dc_rtag), 64'd9);
    tick();
    chk("t5_out1", 64'(bus_if.outstanding), 64'd1);
    ret(4'd1, 1'b0, 1'b0, 1'b0);
    ret(4'd9, 1'b1, 1'b0, 1'b0);

    // 6: return and re-accept of the same tag in one cycle
    idle();
    bus_if.ic_req = 1'b1; bus_if.mem2proc_response = 4'd4;
    tick();
    idle();
    bus_if.dc_req = 1'b1; bus_if.mem2proc_response = 4'd4; bus_if.mem2proc_tag = 4'd4;
    #1;
    chk("t6_prev_owner", 64'(bus_if.ic_rvalid), 64'd1);
    chk("t6_dc_rvalid0", 64'(bus_if.dc_rvalid), 64'd0);
    chk("t6_dc_gnt", 64'(bus_if.dc_gnt), 64'd1);
    tick();
    chk("t6_out_same", 64'(bus_if.outstanding), 64'd1);
    ret(4'd4, 1'b1, 1'b0, 1'b0);
    chk("t6_out0", 64'(bus_if.outstanding), 64'd0);

    // Reset mid-flight abandons the entry
    idle();
    bus_if.ic_req = 1'b1; bus_if.mem2proc_response = 4'd2;
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ret(4'd2, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_out", 64'(bus_if.outstanding), 64'd0);

    // 7: prefetch flush (drop only when the feature is built in)
    idle();
    bus_if.pf_req = 1'b1; bus_if.mem2proc_response = 4'd2;
    tick();
    bus_if.mem2proc_response = 4'd3;
    tick();
    idle();
    bus_if.pf_flush = 1'b1;
    tick();
    chk("t7_out2", 64'(bus_if.outstanding), 64'd2);
    ret(4'd2, 1'b0, 1'b0, EXP_PF_RV);
    chk("t7_out1", 64'(bus_if.outstanding), 64'd1);
    ret(4'd3, 1'b0, 1'b0, EXP_PF_RV);
    chk("t7_out0", 64'(bus_if.outstanding), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
